// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file: default geometry and
// architecturally named register indices.
package wb_regfile_pkg;

    localparam int REGFILE_DW    = 32;
    localparam int REGFILE_AW    = 5;
    localparam int REGFILE_CNT_W = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_bypass.sv
// One read-port mux: forwards the word being written back this cycle when it
// targets the requested register, otherwise passes the stored word through.
module regfile_bypass
    import wb_regfile_pkg::*;
#(
    parameter int DW = REGFILE_DW,
    parameter int AW = REGFILE_AW
) (
    input  logic [AW-1:0] idx,
    input  logic          WE,
    input  logic [AW-1:0] Rw,
    input  logic [DW-1:0] DataIn,
    input  logic [DW-1:0] stored,
    output logic [DW-1:0] word
);

    // r0 never forwards, so a discarded write to r0 cannot leak onto a bus.
    always_comb begin
        word = stored;
        if (idx == AW'(REG_ZERO)) begin
            word = '0;
        end else if (WE && (Rw == idx)) begin
            word = DataIn;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// 32 x 32 general-purpose register file with a same-cycle write-to-read bypass,
// hardwired-zero r0, a non-bypassed debug port and a retired-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW    = REGFILE_DW,
    parameter int AW    = REGFILE_AW,
    parameter int CNT_W = REGFILE_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             WE,
    input  logic [AW-1:0]    Rw,
    input  logic [DW-1:0]    DataIn,
    input  logic [AW-1:0]    Ra,
    input  logic [AW-1:0]    Rb,
    output logic [DW-1:0]    busA,
    output logic [DW-1:0]    busB,
    input  logic [AW-1:0]    dbg_idx,
    output logic [DW-1:0]    dbg_data,
    output logic [CNT_W-1:0] wr_count
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] regs [DEPTH];
    logic [DW-1:0] stored_a;
    logic [DW-1:0] stored_b;
    logic          commit;
    logic          bypass_we;

    assign commit = WE && (Rw != AW'(REG_ZERO));

    // Reset wins over a simultaneous write; r0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit) begin
            regs[Rw] <= DataIn;
            wr_count <= wr_count + 1'b1;
        end
    end

    assign stored_a = (Ra == AW'(REG_ZERO))      ? '0 : regs[Ra];
    assign stored_b = (Rb == AW'(REG_ZERO))      ? '0 : regs[Rb];
    assign dbg_data = (dbg_idx == AW'(REG_ZERO)) ? '0 : regs[dbg_idx];

    // While in reset the pending write is ignored, so the buses must not forward it.
    assign bypass_we = WE && rst_n;

    regfile_bypass #(.DW(DW), .AW(AW)) u_bypass_a (
        .idx    (Ra),
        .WE     (bypass_we),
        .Rw     (Rw),
        .DataIn (DataIn),
        .stored (stored_a),
        .word   (busA)
    );

    regfile_bypass #(.DW(DW), .AW(AW)) u_bypass_b (
        .idx    (Rb),
        .WE     (bypass_we),
        .Rw     (Rw),
        .DataIn (DataIn),
        .stored (stored_b),
        .word   (busB)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; the counter is built 4 bits wide
// so that wrap-around is reachable in a few writes.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             WE;
    logic [AW-1:0]    Rw;
    logic [DW-1:0]    DataIn;
    logic [AW-1:0]    Ra;
    logic [AW-1:0]    Rb;
    logic [DW-1:0]    busA;
    logic [DW-1:0]    busB;
    logic [AW-1:0]    dbg_idx;
    logic [DW-1:0]    dbg_data;
    logic [CNT_W-1:0] wr_count;

    int compared;
    int mismatched;

    wb_regfile #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .WE       (WE),
        .Rw       (Rw),
        .DataIn   (DataIn),
        .Ra       (Ra),
        .Rb       (Rb),
        .busA     (busA),
        .busB     (busB),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        WE    = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] idx, input logic [DW-1:0] data);
        WE     = 1'b1;
        Rw     = idx;
        DataIn = data;
        tick();
        WE = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        WE      = 1'b1;
        Rw      = 5'd5;
        DataIn  = 32'hDEAD_BEEF;
        Ra      = 5'd5;
        Rb      = 5'd5;
        dbg_idx = 5'd5;
        tick();
        tick();
        compared++;
        if (busA !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_busA_during_reset: got %h expected %h", busA, 32'h0);
        end
        rst_n = 1'b1;
        WE    = 1'b0;
        #1;
        compared++;
        if (busA !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_busA: got %h expected %h", busA, 32'h0);
        end
        compared++;
        if (wr_count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_wr_count: got %0d expected %0d", wr_count, 0);
        end
        compared++;
        if (dbg_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_dbg: got %h expected %h", dbg_data, 32'h0);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        write_reg(5'd7, 32'h1234_5678);
        Ra      = 5'd7;
        Rb      = 5'd7;
        dbg_idx = 5'd7;
        Rw      = 5'd7;
        DataIn  = 32'hAAAA_AAAA;
        #1;
        compared++;
        if (busA !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL wr_busA: got %h expected %h", busA, 32'h1234_5678);
        end
        compared++;
        if (busB !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL wr_busB: got %h expected %h", busB, 32'h1234_5678);
        end
        compared++;
        if (dbg_data !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL wr_dbg: got %h expected %h", dbg_data, 32'h1234_5678);
        end
        compared++;
        if (wr_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL wr_count: got %0d expected %0d", wr_count, 1);
        end
    endtask

    task automatic test_r0_write();
        WE      = 1'b1;
        Rw      = 5'd0;
        DataIn  = 32'hFFFF_FFFF;
        Ra      = 5'd0;
        #1;
        compared++;
        if (busA !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL r0_bypass_busA: got %h expected %h", busA, 32'h0);
        end
        tick();
        WE      = 1'b0;
        dbg_idx = 5'd0;
        #1;
        compared++;
        if (busA !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL r0_busA: got %h expected %h", busA, 32'h0);
        end
        compared++;
        if (dbg_data !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL r0_dbg: got %h expected %h", dbg_data, 32'h0);
        end
        compared++;
        if (wr_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL r0_wr_count: got %0d expected %0d", wr_count, 1);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        write_reg(5'd3, 32'h11);
        WE      = 1'b1;
        Rw      = 5'd3;
        DataIn  = 32'h22;
        Ra      = 5'd3;
        Rb      = 5'd3;
        dbg_idx = 5'd3;
        #1;
        compared++;
        if (busA !== 32'h22) begin
            mismatched++;
            $display("[TB] FAIL bypass_busA: got %h expected %h", busA, 32'h22);
        end
        compared++;
        if (busB !== 32'h22) begin
            mismatched++;
            $display("[TB] FAIL bypass_busB: got %h expected %h", busB, 32'h22);
        end
        compared++;
        if (dbg_data !== 32'h11) begin
            mismatched++;
            $display("[TB] FAIL bypass_dbg_before: got %h expected %h", dbg_data, 32'h11);
        end
        tick();
        WE = 1'b0;
        #1;
        compared++;
        if (dbg_data !== 32'h22) begin
            mismatched++;
            $display("[TB] FAIL bypass_dbg_after: got %h expected %h", dbg_data, 32'h22);
        end
        compared++;
        if (wr_count !== 4'd2) begin
            mismatched++;
            $display("[TB] FAIL bypass_wr_count: got %0d expected %0d", wr_count, 2);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        Rb = 5'd2;
        WE = 1'b1;
        Rw = 5'd1; DataIn = 32'd1;
        tick();
        Rw = 5'd2; DataIn = 32'd2;
        tick();
        Rw = 5'd1; DataIn = 32'd3;
        #1;
        compared++;
        if (busB !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_busB_third: got %h expected %h", busB, 32'd2);
        end
        tick();
        WE      = 1'b0;
        Ra      = 5'd1;
        dbg_idx = 5'd2;
        #1;
        compared++;
        if (busA !== 32'd3) begin
            mismatched++;
            $display("[TB] FAIL b2b_r1: got %h expected %h", busA, 32'd3);
        end
        compared++;
        if (dbg_data !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL b2b_r2: got %h expected %h", dbg_data, 32'd2);
        end
        compared++;
        if (wr_count !== 4'd3) begin
            mismatched++;
            $display("[TB] FAIL b2b_wr_count: got %0d expected %0d", wr_count, 3);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            write_reg(5'd9, 32'd100 + 32'(i));
        end
        dbg_idx = 5'd9;
        #1;
        compared++;
        if (wr_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL wrap_wr_count: got %0d expected %0d", wr_count, 1);
        end
        compared++;
        if (dbg_data !== 32'd116) begin
            mismatched++;
            $display("[TB] FAIL wrap_r9: got %0d expected %0d", dbg_data, 116);
        end
    endtask

    task automatic test_x_safety();
        do_reset();
        write_reg(REG_SP, 32'h0000_AA55);
        write_reg(REG_RA, 32'h0040_0010);
        Ra = REG_SP;
        Rb = REG_RA;
        WE = 1'b0;
        Rw = REG_SP;
        DataIn = 32'h5A5A_0F0F;
        #1;
        compared++;
        if (busA !== 32'h0000_AA55) begin
            mismatched++;
            $display("[TB] FAIL xsafe_busA: got %h expected %h", busA, 32'h0000_AA55);
        end
        compared++;
        if (busB !== 32'h0040_0010) begin
            mismatched++;
            $display("[TB] FAIL xsafe_busB: got %h expected %h", busB, 32'h0040_0010);
        end
        tick();
        compared++;
        if (wr_count !== 4'd2) begin
            mismatched++;
            $display("[TB] FAIL xsafe_wr_count: got %0d expected %0d", wr_count, 2);
        end
        rst_n  = 1'b0;
        WE     = 1'b1;
        DataIn = 32'h0000_1234;
        #1;
        compared++;
        if (busA !== 32'h0000_AA55) begin
            mismatched++;
            $display("[TB] FAIL reset_gates_bypass: got %h expected %h", busA, 32'h0000_AA55);
        end
        tick();
        compared++;
        if (busA !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_clears_sp: got %h expected %h", busA, 32'h0);
        end
        rst_n = 1'b1;
        WE    = 1'b0;
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        WE         = 1'b0;
        Rw         = '0;
        DataIn     = '0;
        Ra         = '0;
        Rb         = '0;
        dbg_idx    = '0;
        test_reset();
        test_write_read();
        test_r0_write();
        test_bypass();
        test_back_to_back();
        test_counter_wrap();
        test_x_safety();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
